// File: rtl/button_event_decoder.sv
// ---------------------------------------------------------------------------
// button_event_decoder
//
// Turns the debounced button level into single-cycle event pulses. Press and
// release ticks come from the edges of db_in. A release before the long
// threshold also gives a short tick. A hold that reaches LONG_MS gives a long
// tick, and after that a repeat tick every REPEAT_MS until release. The block
// also keeps an 8-bit wrapping press counter and a "held" level.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   db_in         debounced button level (1 = pressed), synchronous to clk
//   press_tick    one-cycle pulse on each press
//   release_tick  one-cycle pulse on each release
//   short_tick    one-cycle pulse on a release before the long threshold
//   long_tick     one-cycle pulse when the hold reaches LONG_MS
//   repeat_tick   one-cycle pulse every REPEAT_MS while long-held
//   held          1 while a press is in progress (PRESSED or LONG)
//   press_count   number of presses, wraps at 256
//
// FSM states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | button released, waiting for a rising edge
//   PRESSED | button down, hold time still below LONG_MS
//   LONG    | button down past LONG_MS, repeat ticks running
// ---------------------------------------------------------------------------
module button_event_decoder #(
  parameter int CLK_PER_MS = 50000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db_in,
  output logic       press_tick,
  output logic       release_tick,
  output logic       short_tick,
  output logic       long_tick,
  output logic       repeat_tick,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int PW = $clog2(CLK_PER_MS);
  localparam int HW = $clog2(LONG_MS);
  localparam int RW = $clog2(REPEAT_MS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_PER_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESSED = 2'b01,
    LONG    = 2'b10
  } state_t;

  state_t        state;
  logic          in_d;
  logic [PW-1:0] prescaler;
  logic [HW-1:0] hold_ms;
  logic [RW-1:0] rpt_ms;

  logic rise;
  logic fall;
  logic ms_tick;

  assign rise    = db_in & ~in_d;
  assign fall    = ~db_in & in_d;
  assign ms_tick = (prescaler == PRE_LAST);

  // The prescaler restarts on every press. This keeps the millisecond
  // boundaries aligned to the press edge, so hold timing does not depend on
  // where the free-running count happened to be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_d      <= 1'b0;
      prescaler <= '0;
    end else begin
      in_d <= db_in;
      if (rise || ms_tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      short_tick   <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;
      held         <= 1'b0;
      press_count  <= 8'd0;
      hold_ms      <= '0;
      rpt_ms       <= '0;
    end else begin
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      short_tick   <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;

      case (state)
        IDLE: begin
          held <= 1'b0;
          if (rise) begin
            state       <= PRESSED;
            press_tick  <= 1'b1;
            press_count <= press_count + 8'd1;
            hold_ms     <= '0;
            held        <= 1'b1;
          end
        end

        // A release wins over the long threshold in the same cycle, so a
        // release at exactly LONG_MS still counts as a short press.
        PRESSED: begin
          held <= 1'b1;
          if (fall) begin
            state        <= IDLE;
            release_tick <= 1'b1;
            short_tick   <= 1'b1;
            held         <= 1'b0;
          end else if (ms_tick) begin
            if (hold_ms == HOLD_LAST) begin
              state     <= LONG;
              long_tick <= 1'b1;
              rpt_ms    <= '0;
            end else begin
              hold_ms <= hold_ms + HW'(1);
            end
          end
        end

        LONG: begin
          held <= 1'b1;
          if (fall) begin
            state        <= IDLE;
            release_tick <= 1'b1;
            held         <= 1'b0;
          end else if (ms_tick) begin
            if (rpt_ms == RPT_LAST) begin
              repeat_tick <= 1'b1;
              rpt_ms      <= '0;
            end else begin
              rpt_ms <= rpt_ms + RW'(1);
            end
          end
        end

        // Unused encoding: recover silently to IDLE.
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
